// File: rtl/dmem_arb_pkg.sv
// Shared types for the bundle memory-slot arbiter:
// FSM states, default widths and the captured lane request.
package dmem_arb_pkg;

  localparam int DMEM_AW = 30;
  localparam int DMEM_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE3,
    WAIT3,
    ISSUE4,
    WAIT4,
    DONE
  } arb_state_t;

  // Captured memory slot. re and we are mutually
  // exclusive once normalised (store wins).
  typedef struct packed {
    logic               re;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] data;
  } lane_req_t;

  function automatic logic lane_active(
    input lane_req_t l
  );
    return l.re | l.we;
  endfunction

  function automatic logic both_loads_same(
    input lane_req_t a,
    input lane_req_t b
  );
    return a.re & b.re & (a.addr == b.addr);
  endfunction

endpackage

// File: rtl/mem_lane_slot.sv
// Capture register for one memory lane of a bundle.
// Ports: clk/rst, ld_en loads re_i/we_i/addr_i/data_i;
// slot_o holds the normalised request (store over load).
module mem_lane_slot
  import dmem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_en,
  input  logic               re_i,
  input  logic               we_i,
  input  logic [DMEM_AW-1:0] addr_i,
  input  logic [DMEM_DW-1:0] data_i,
  output lane_req_t          slot_o
);

  lane_req_t slot_q;
  lane_req_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (ld_en) begin
      // both enables set means store
      slot_d.we   = we_i;
      slot_d.re   = re_i & ~we_i;
      slot_d.addr = addr_i;
      slot_d.data = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Serialises bundle memory lanes 3 and 4 onto one cache port.
// Ports: dec_* lane requests in, ext_stall in, mem_stall out,
// c_* cache request/response, wb_memdata3/4 load results.
module dmem_lane_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_mre3,
  input  logic          dec_mwe3,
  input  logic [AW-1:0] daddr3,
  input  logic [DW-1:0] op32,
  input  logic          dec_mre4,
  input  logic          dec_mwe4,
  input  logic [AW-1:0] daddr4,
  input  logic [DW-1:0] op42,
  input  logic          ext_stall,
  output logic          mem_stall,
  output logic          c_req,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_wdata,
  input  logic          c_ready,
  input  logic          c_rvalid,
  input  logic [DW-1:0] c_rdata,
  output logic [DW-1:0] wb_memdata3,
  output logic [DW-1:0] wb_memdata4
);

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [DW-1:0] wb3_q;
  logic [DW-1:0] wb3_d;
  logic [DW-1:0] wb4_q;
  logic [DW-1:0] wb4_d;

  lane_req_t l3;
  lane_req_t l4;

  logic act3_in;
  logic act4_in;
  logic cap_en;
  logic busy;

  assign act3_in = dec_mre3 | dec_mwe3;
  assign act4_in = dec_mre4 | dec_mwe4;

  // Capture only on the IDLE cycle that starts a bundle.
  assign cap_en = (state_q == IDLE)
                & (act3_in | act4_in)
                & ~ext_stall;

  mem_lane_slot u_slot3 (
    .clk    (clk),
    .rst    (rst),
    .ld_en  (cap_en),
    .re_i   (dec_mre3),
    .we_i   (dec_mwe3),
    .addr_i (daddr3),
    .data_i (op32),
    .slot_o (l3)
  );

  mem_lane_slot u_slot4 (
    .clk    (clk),
    .rst    (rst),
    .ld_en  (cap_en),
    .re_i   (dec_mre4),
    .we_i   (dec_mwe4),
    .addr_i (daddr4),
    .data_i (op42),
    .slot_o (l4)
  );

  always_comb begin
    state_d = state_q;
    wb3_d   = wb3_q;
    wb4_d   = wb4_q;
    c_req   = 1'b0;
    c_we    = 1'b0;
    c_addr  = '0;
    c_wdata = '0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_en) begin
          state_d = act3_in ? ISSUE3 : ISSUE4;
        end
      end
      ISSUE3: begin
        busy    = 1'b1;
        c_req   = 1'b1;
        c_we    = l3.we;
        c_addr  = l3.addr;
        c_wdata = l3.data;
        if (c_ready) begin
          state_d = WAIT3;
        end
      end
      WAIT3: begin
        busy = 1'b1;
        if (c_rvalid) begin
          if (l3.re) begin
            wb3_d = c_rdata;
          end
          // load/load to one word: share the response
          if (both_loads_same(l3, l4)) begin
            wb4_d   = c_rdata;
            state_d = DONE;
          end else if (lane_active(l4)) begin
            state_d = ISSUE4;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE4: begin
        busy    = 1'b1;
        c_req   = 1'b1;
        c_we    = l4.we;
        c_addr  = l4.addr;
        c_wdata = l4.data;
        if (c_ready) begin
          state_d = WAIT4;
        end
      end
      WAIT4: begin
        busy = 1'b1;
        if (c_rvalid) begin
          if (l4.re) begin
            wb4_d = c_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // hold here so a stalled bundle is not replayed
        if (!ext_stall) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_stall = cap_en | busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wb3_q   <= '0;
      wb4_q   <= '0;
    end else begin
      state_q <= state_d;
      wb3_q   <= wb3_d;
      wb4_q   <= wb4_d;
    end
  end

  assign wb_memdata3 = wb3_q;
  assign wb_memdata4 = wb4_q;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Randomised bench for dmem_lane_arbiter against a
// bundle-level model of serial lane execution.
module tb_dmem_lane_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_mre3, dec_mwe3, dec_mre4, dec_mwe4;
  logic [AW-1:0] daddr3, daddr4;
  logic [DW-1:0] op32, op42;
  logic          ext_stall;
  logic          mem_stall;
  logic          c_req, c_we, c_ready, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic [DW-1:0] wb_memdata3, wb_memdata4;

  always #5 clk = ~clk;

  dmem_lane_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_mre3    (dec_mre3),
    .dec_mwe3    (dec_mwe3),
    .daddr3      (daddr3),
    .op32        (op32),
    .dec_mre4    (dec_mre4),
    .dec_mwe4    (dec_mwe4),
    .daddr4      (daddr4),
    .op42        (op42),
    .ext_stall   (ext_stall),
    .mem_stall   (mem_stall),
    .c_req       (c_req),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_ready     (c_ready),
    .c_rvalid    (c_rvalid),
    .c_rdata     (c_rdata),
    .wb_memdata3 (wb_memdata3),
    .wb_memdata4 (wb_memdata4)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xreq_t;

  xreq_t         exp_q[$];
  logic [DW-1:0] cache_mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] exp_wb3 = '0;
  logic [DW-1:0] exp_wb4 = '0;

  int            req_idx = 0;
  int            wait_cnt = 0;
  int            dly[2];
  int            lat[2];
  bit            pend = 0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data = '0;
  bit            spur_ok = 0;

  function automatic logic [DW-1:0] cache_rd(logic [AW-1:0] a);
    return cache_mem.exists(a) ? cache_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // advance to just after the next rising edge and
  // play the cache for that cycle
  task automatic tick();
    @(posedge clk);
    #1;
    c_rvalid = 1'b0;
    c_rdata  = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        c_rvalid = 1'b1;
        c_rdata  = pend_data;
        pend     = 0;
      end
    end else if ((c_req || spur_ok) &&
                 $urandom_range(3) == 0) begin
      c_rvalid = 1'b1;
    end
    c_ready = 1'($urandom_range(1));
    if (c_req) begin
      if (req_idx >= exp_q.size()) begin
        chk("extra_req", 1, 0);
        c_ready   = 1'b1;
        pend      = 1;
        pend_cnt  = 1;
        pend_data = '0;
      end else begin
        chk("c_we", c_we, exp_q[req_idx].we);
        chk("c_addr", c_addr, exp_q[req_idx].addr);
        chk("c_wdata", c_wdata, exp_q[req_idx].data);
        c_ready = (wait_cnt >= dly[req_idx]);
        if (c_ready) begin
          if (c_we) cache_mem[c_addr] = c_wdata;
          pend_data = c_we ? DW'($urandom) : cache_rd(c_addr);
          pend      = 1;
          pend_cnt  = lat[req_idx];
          req_idx++;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  // lane type: 0 none, 1 load, 2 store, 3 both (store)
  task automatic run_bundle(
    int t3, logic [AW-1:0] a3, logic [DW-1:0] d3,
    int t4, logic [AW-1:0] a4, logic [DW-1:0] d4,
    int d0, int l0, int d1, int l1, int hold, int pre);
    bit re3, we3, re4, we4;
    int exp_stall;
    int stalls;
    bit done;
    re3 = (t3 == 1);
    we3 = (t3 >= 2);
    re4 = (t4 == 1);
    we4 = (t4 >= 2);
    exp_q.delete();
    req_idx  = 0;
    wait_cnt = 0;
    dly[0] = d0; lat[0] = l0;
    dly[1] = d1; lat[1] = l1;
    if (re3 || we3) begin
      exp_q.push_back('{we3, a3, d3});
      if (we3) ref_mem[a3] = d3;
      else exp_wb3 = ref_rd(a3);
    end
    if (re3 && re4 && a3 == a4) begin
      exp_wb4 = exp_wb3;
    end else if (re4 || we4) begin
      exp_q.push_back('{we4, a4, d4});
      if (we4) ref_mem[a4] = d4;
      else exp_wb4 = ref_rd(a4);
    end
    exp_stall = 1;
    for (int k = 0; k < exp_q.size(); k++)
      exp_stall += dly[k] + 1 + lat[k];

    dec_mre3 = t3[0]; dec_mwe3 = t3[1];
    daddr3 = a3; op32 = d3;
    dec_mre4 = t4[0]; dec_mwe4 = t4[1];
    daddr4 = a4; op42 = d4;
    spur_ok = 0;

    if (pre > 0) begin
      ext_stall = 1'b1;
      for (int i = 0; i < pre; i++) begin
        @(negedge clk);
        chk("pre_stall", mem_stall, 0);
        chk("pre_creq", c_req, 0);
        tick();
      end
    end
    ext_stall = 1'b0;

    stalls = 0;
    done   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1;
        break;
      end
      stalls++;
      tick();
      ext_stall = (hold > 0);
    end
    chk("done_seen", done, 1);
    chk("stall_cycles", stalls, exp_stall);
    chk("wb3", wb_memdata3, exp_wb3);
    chk("wb4", wb_memdata4, exp_wb4);
    chk("req_count", req_idx, exp_q.size());
    chk("done_creq", c_req, 0);

    spur_ok = 1;
    for (int i = 1; i < hold; i++) begin
      tick();
      @(negedge clk);
      chk("hold_stall", mem_stall, 0);
      chk("hold_creq", c_req, 0);
    end
    if (hold > 0) begin
      tick();
      ext_stall = 1'b0;
      @(negedge clk);
      chk("release_stall", mem_stall, 0);
      chk("release_creq", c_req, 0);
    end
    tick();
    spur_ok = 0;
  endtask

  task automatic reset_in_wait3();
    exp_q.delete();
    req_idx  = 0;
    wait_cnt = 0;
    dly[0] = 0; lat[0] = 5;
    exp_q.push_back('{1'b0, 30'h0A5, 32'h0});
    exp_q[0].data = 32'h1234_5678;
    dec_mre3 = 1'b1; dec_mwe3 = 1'b0;
    daddr3 = 30'h0A5; op32 = 32'h1234_5678;
    dec_mre4 = 1'b0; dec_mwe4 = 1'b0;
    cache_mem[30'h0A5] = 32'hCAFE_F00D;
    ref_mem[30'h0A5] = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("rst_pre_stall", mem_stall, 1);
    chk("rst_pre_acc", req_idx, 1);
    rst = 1'b1;
    dec_mre3 = 1'b0;
    tick();
    rst = 1'b0;
    spur_ok = 1;
    exp_wb3 = '0;
    exp_wb4 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_stall", mem_stall, 0);
      chk("rst_creq", c_req, 0);
      chk("rst_caddr", c_addr, 0);
      chk("rst_wb3", wb_memdata3, 0);
      chk("rst_wb4", wb_memdata4, 0);
      tick();
    end
    spur_ok = 0;
    chk("rst_stale_gone", pend, 0);
  endtask

  initial begin
    rst = 1'b1;
    dec_mre3 = 0; dec_mwe3 = 0; dec_mre4 = 0; dec_mwe4 = 0;
    daddr3 = '0; daddr4 = '0; op32 = '0; op42 = '0;
    ext_stall = 0; c_ready = 0; c_rvalid = 0; c_rdata = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mem_stall", mem_stall, 0);
    chk("rst_c_req", c_req, 0);
    chk("rst_c_we", c_we, 0);
    chk("rst_c_addr", c_addr, 0);
    chk("rst_c_wdata", c_wdata, 0);
    chk("rst_wb3", wb_memdata3, 0);
    chk("rst_wb4", wb_memdata4, 0);
    tick();
    rst = 1'b0;

    spur_ok = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_stall", mem_stall, 0);
      chk("idle_creq", c_req, 0);
      tick();
    end
    spur_ok = 0;

    cache_mem[30'h10] = 32'hDEAD_BEEF;
    ref_mem[30'h10]   = 32'hDEAD_BEEF;
    cache_mem[30'h40] = 32'h4040_0404;
    ref_mem[30'h40]   = 32'h4040_0404;

    // lane-3 load only
    run_bundle(1, 30'h10, 32'h0, 0, 30'h0, 32'h0,
               0, 1, 0, 1, 0, 0);
    // store then load, same word
    run_bundle(2, 30'h20, 32'h5, 1, 30'h20, 32'h0,
               0, 1, 0, 1, 0, 0);
    // load/load same word: one request
    run_bundle(1, 30'h40, 32'h0, 1, 30'h40, 32'h0,
               0, 1, 0, 1, 0, 0);
    // c_ready low 4 cycles on lane 4
    run_bundle(1, 30'h10, 32'h0, 2, 30'h30, 32'h77,
               0, 1, 4, 1, 0, 0);
    // ext_stall held in DONE
    run_bundle(0, 30'h0, 32'h0, 1, 30'h30, 32'h0,
               0, 1, 0, 1, 3, 0);
    // two stores to one word, then read it back
    run_bundle(3, 30'h50, 32'hAAAA, 2, 30'h50, 32'hBBBB,
               0, 1, 0, 2, 0, 1);
    run_bundle(1, 30'h50, 32'h0, 0, 30'h0, 32'h0,
               0, 1, 0, 1, 0, 0);

    reset_in_wait3();

    for (int n = 0; n < 60; n++) begin
      int t3, t4;
      t3 = $urandom_range(3);
      t4 = $urandom_range(3);
      if (t3 == 0 && t4 == 0) t3 = 1;
      run_bundle(t3, AW'($urandom_range(3)), $urandom,
                 t4, AW'($urandom_range(3)), $urandom,
                 $urandom_range(2), $urandom_range(1, 3),
                 $urandom_range(2), $urandom_range(1, 3),
                 $urandom_range(2), $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_lane_arbiter.md
# dmem_lane_arbiter

Serialises the two memory slots of a VLIW bundle (lanes 3 and 4) onto the single-ported data cache. It sits between decode and the data-cache port. It enforces in-bundle program order (lane 3 before lane 4) and raises a memory stall until both lanes are serviced. Load results are returned on per-lane registered outputs feeding writeback/forwarding.

## Interface
Parameters:
- AW, 30: word-address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dec_mre3, dec_mwe3  in  1 each  lane-3 read/write enable from decode.
- daddr3  in  AW  lane-3 word address.
- op32  in  DW  lane-3 store data.
- dec_mre4, dec_mwe4, daddr4, op42  in  1/1/AW/DW  lane-4 equivalents.
- ext_stall  in  1  OR of all non-memory stall sources.
- mem_stall  out  1  pipeline hold request.
- c_req  out  1  cache request valid.
- c_we  out  1  1 = store.
- c_addr  out  AW  cache address.
- c_wdata  out  DW  cache store data.
- c_ready  in  1  request accepted this cycle.
- c_rvalid  in  1  response/ack; one per accepted request, at least 1 cycle after acceptance.
- c_rdata  in  DW  load data, valid with c_rvalid.
- wb_memdata3, wb_memdata4  out  DW  load results; held until overwritten by a later load on the same lane.

## Operation
- States: IDLE, ISSUE3, WAIT3, ISSUE4, WAIT4, DONE.
- A lane is active if mre|mwe. If both bits are set, the lane is a store (mwe priority).
- IDLE, any lane active, !ext_stall:
  - Capture both lanes (enables, address, data) into per-lane registers.
  - Go to ISSUE3 if lane 3 is active, else ISSUE4.
  - If ext_stall is high, remain in IDLE and capture nothing.
- ISSUEn:
  - c_req=1, with c_we/c_addr/c_wdata taken from the captured lane n.
  - Stay until c_ready, then go to WAITn.
- WAIT3, on c_rvalid:
  - Latch c_rdata into wb_memdata3 if lane 3 is a load.
  - Go to ISSUE4 if lane 4 is active, else DONE.
  - Same-address load/load shortcut: if both lanes are loads and the captured addresses are equal, wb_memdata4 takes the same c_rdata and the FSM goes straight to DONE.
- WAIT4, on c_rvalid: latch wb_memdata4 if lane 4 is a load, then go to DONE.
- DONE: mem_stall=0 so the pipeline advances.
  - Stay in DONE while ext_stall=1, so the same bundle is never re-executed.
  - Go to IDLE when ext_stall=0.
- In-bundle hazards resolve through serial order:
  - Lane-3 store then lane-4 load to the same address: the load returns the stored value.
  - Two stores to the same address: lane 4's value wins.
- c_rvalid in IDLE, ISSUEn or DONE is ignored. This covers stale responses after reset.

## Timing
- mem_stall = (IDLE & any_active & !ext_stall) | (state ∈ {ISSUE3, WAIT3, ISSUE4, WAIT4}). The IDLE term is combinational from the dec_* inputs so decode holds in the first cycle.
- c_req is a registered-state output (Moore). It never depends combinationally on c_ready.
- Cycle counts with c_ready=1 and c_rvalid one cycle after acceptance:
  - One-lane bundle: stall cycles 0–2 (IDLE, ISSUE, WAIT); DONE at cycle 3.
  - Two-lane bundle: stall cycles 0–4; DONE at cycle 5.
  - Load/load same-address bundle: same as one-lane.
- Reset values:
  - state=IDLE.
  - mem_stall=0 (IDLE term still applies combinationally).
  - c_req=0, c_we=0, c_addr=0, c_wdata=0.
  - wb_memdata3=wb_memdata4=0.
  - Capture registers cleared.
- rst in any state aborts the bundle next cycle and drops any pending response. A store that already received c_ready is not rolled back.
- A bundle with no active lane never stalls and never leaves IDLE.

## Structure
- Shared package dmem_arb_pkg:
  - state enum arb_state_t.
  - AW/DW defaults.
  - Lane struct lane_req_t {re, we, addr, data}.
- Sub-module mem_lane_slot, instantiated twice: a capture register for lane_req_t with load enable and the mwe-priority normalisation.
- FSM, cache mux and result registers live in the top module.

## Test plan
- Lane-3 load only, addr 0x10, cache returns 0xDEADBEEF one cycle after accept -> mem_stall high 3 cycles, wb_memdata3=0xDEADBEEF at DONE, wb_memdata4 unchanged.
- Lane-3 store 0x5 to 0x20 and lane-4 load from 0x20 (model cache) -> c_req order store then load; wb_memdata4=0x5; 5 stall cycles.
- Both lanes load 0x40 -> exactly one c_req; wb_memdata3=wb_memdata4=cache value.
- c_ready held low 4 cycles in ISSUE4 -> c_req and c_addr stable throughout; stall extends by 4 cycles.
- ext_stall=1 during DONE for 3 cycles -> no new c_req; mem_stall=0; IDLE only after ext_stall falls.
- rst asserted in WAIT3, stale c_rvalid arrives after -> IDLE, outputs zero, response ignored, no c_req.
